// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg
//   Shared definitions for the data-memory responder:
//   - funct3 size codes (SZ_B .. SZ_ILL)
//   - read/write encoding of MEM_Cst_R_W
//   - clear FSM state enum
//   - size_mask(): byte-enable pattern for a log2 access width
package dmem_responder_pkg;

  localparam logic [2:0] SZ_B   = 3'b000;
  localparam logic [2:0] SZ_H   = 3'b001;
  localparam logic [2:0] SZ_W   = 3'b010;
  localparam logic [2:0] SZ_D   = 3'b011;
  localparam logic [2:0] SZ_BU  = 3'b100;
  localparam logic [2:0] SZ_HU  = 3'b101;
  localparam logic [2:0] SZ_WU  = 3'b110;
  localparam logic [2:0] SZ_ILL = 3'b111;

  localparam logic RW_LOAD  = 1'b0;
  localparam logic RW_STORE = 1'b1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } clr_state_t;

  // Unshifted byte-enable pattern for 1/2/4/8-byte accesses.
  function automatic logic [7:0] size_mask(input logic [1:0] lg);
    case (lg)
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if
//   Pipeline-to-data-memory bus.
//   master: drives MEM_V, MEM_Cst_R_W, MEM_Cst_Size, MEM_Address, MEM_RES;
//           receives MEM_Data_Out and the DMEM_* status/counter outputs.
//   slave : the reverse (the memory responder).
//
// Handshake: MEM_V marks a single-cycle access; there is no ready signal.
// The access is accepted in the same cycle iff MEM_V=1, DMEM_BUSY=0 and
// neither DMEM_MISALIGN nor DMEM_FAULT is set. Load data is combinational
// in that cycle; store data is written on the following rising edge. While
// DMEM_BUSY=1 the master must stall and re-issue; dropped accesses have no
// side effect.
interface dmem_responder_if;
  logic        MEM_V;
  logic        MEM_Cst_R_W;
  logic [2:0]  MEM_Cst_Size;
  logic [63:0] MEM_Address;
  logic [63:0] MEM_RES;
  logic [63:0] MEM_Data_Out;
  logic        DMEM_BUSY;
  logic        DMEM_MISALIGN;
  logic        DMEM_FAULT;
  logic        DMEM_ERR;
  logic [31:0] DMEM_LD_CNT;
  logic [31:0] DMEM_ST_CNT;

  modport master (
    output MEM_V, MEM_Cst_R_W, MEM_Cst_Size, MEM_Address, MEM_RES,
    input  MEM_Data_Out, DMEM_BUSY, DMEM_MISALIGN, DMEM_FAULT, DMEM_ERR,
           DMEM_LD_CNT, DMEM_ST_CNT
  );

  modport slave (
    input  MEM_V, MEM_Cst_R_W, MEM_Cst_Size, MEM_Address, MEM_RES,
    output MEM_Data_Out, DMEM_BUSY, DMEM_MISALIGN, DMEM_FAULT, DMEM_ERR,
           DMEM_LD_CNT, DMEM_ST_CNT
  );
endinterface

// File: rtl/dmem_lane_ctl.sv
// dmem_lane_ctl
//   Combinational byte-lane unit for one doubleword.
//   is_store : 1 = store (size uses size[1:0] only), 0 = load
//   size     : funct3 size code
//   offset   : byte offset within the doubleword (address[2:0])
//   st_data  : right-aligned store data
//   rd_dw    : doubleword currently stored at the addressed entry
//   byte_en  : lanes written by a store
//   wr_data  : store data shifted into its lanes
//   misalign : access not naturally aligned
//   ld_data  : extracted and sign/zero-extended load data
module dmem_lane_ctl
  import dmem_responder_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  size,
  input  logic [2:0]  offset,
  input  logic [63:0] st_data,
  input  logic [63:0] rd_dw,
  output logic [7:0]  byte_en,
  output logic [63:0] wr_data,
  output logic        misalign,
  output logic [63:0] ld_data
);

  logic [63:0] shifted;

  always_comb begin
    byte_en = size_mask(size[1:0]) << offset;
    wr_data = st_data << {offset, 3'b000};

    case (size[1:0])
      2'd1:    misalign = offset[0];
      2'd2:    misalign = (offset[1:0] != 2'b00);
      2'd3:    misalign = (offset != 3'b000);
      default: misalign = 1'b0;
    endcase
    // Load code 111 is reported as a fault, not as a misaligned D.
    if (!is_store && size == SZ_ILL) misalign = 1'b0;

    shifted = rd_dw >> {offset, 3'b000};
    case (size)
      SZ_B:    ld_data = {{56{shifted[7]}},  shifted[7:0]};
      SZ_H:    ld_data = {{48{shifted[15]}}, shifted[15:0]};
      SZ_W:    ld_data = {{32{shifted[31]}}, shifted[31:0]};
      SZ_D:    ld_data = shifted;
      SZ_BU:   ld_data = {56'd0, shifted[7:0]};
      SZ_HU:   ld_data = {48'd0, shifted[15:0]};
      SZ_WU:   ld_data = {32'd0, shifted[31:0]};
      default: ld_data = 64'd0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
//   Single-port doubleword data memory with byte-lane stores, combinational
//   loads, alignment/range checking and a self-clear after reset.
//   CLK       : clock, all state on the rising edge
//   RESET     : synchronous active-high reset; restarts the clear
//   bus       : dmem_responder_if.slave (access request, load data, status,
//               load/store counters)
//   state_dbg : current clear FSM state
//   DEPTH_DW  : number of 64-bit entries (power of two, >= 2)
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_DW = 256
) (
  input  logic                    CLK,
  input  logic                    RESET,
  dmem_responder_if.slave         bus,
  output clr_state_t              state_dbg
);

  localparam int AW = $clog2(DEPTH_DW);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_DW - 1);

  logic [63:0]   mem [DEPTH_DW];

  clr_state_t    state, state_nxt;
  logic [AW-1:0] clr_ptr, clr_ptr_nxt;

  logic          busy, is_store, fault, misalign, misalign_raw, accept;
  logic [AW-1:0] idx;
  logic [7:0]    byte_en;
  logic [63:0]   wr_data, ld_data, rd_dw;
  logic          err_q;
  logic [31:0]   ld_cnt, st_cnt;

  assign idx   = bus.MEM_Address[AW+2:3];
  assign rd_dw = mem[idx];

  dmem_lane_ctl u_lane (
    .is_store (is_store),
    .size     (bus.MEM_Cst_Size),
    .offset   (bus.MEM_Address[2:0]),
    .st_data  (bus.MEM_RES),
    .rd_dw    (rd_dw),
    .byte_en  (byte_en),
    .wr_data  (wr_data),
    .misalign (misalign_raw),
    .ld_data  (ld_data)
  );

  always_comb begin
    busy     = (state == ST_CLEAR);
    is_store = (bus.MEM_Cst_R_W == RW_STORE);
    // Any address bit above the array span puts the access out of range.
    fault    = bus.MEM_V &&
               (((bus.MEM_Address >> (AW + 3)) != 64'd0) ||
                (!is_store && bus.MEM_Cst_Size == SZ_ILL));
    misalign = bus.MEM_V && misalign_raw;
    accept   = bus.MEM_V && !busy && !fault && !misalign;
  end

  assign bus.MEM_Data_Out  = (accept && !is_store) ? ld_data : 64'd0;
  assign bus.DMEM_BUSY     = busy;
  assign bus.DMEM_MISALIGN = misalign;
  assign bus.DMEM_FAULT    = fault;
  assign bus.DMEM_ERR      = err_q;
  assign bus.DMEM_LD_CNT   = ld_cnt;
  assign bus.DMEM_ST_CNT   = st_cnt;
  assign state_dbg         = state;

  // Clear FSM: one entry zeroed per cycle, READY once the last is written.
  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    if (state == ST_CLEAR) begin
      clr_ptr_nxt = clr_ptr + 1'b1;
      if (clr_ptr == LAST_IDX) state_nxt = ST_READY;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
    end
  end

  // Array has no reset; the clear sequence defines its contents.
  always_ff @(posedge CLK) begin
    if (busy) begin
      mem[clr_ptr] <= 64'd0;
    end else if (accept && is_store) begin
      for (int b = 0; b < 8; b++) begin
        if (byte_en[b]) mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      err_q  <= 1'b0;
      ld_cnt <= 32'd0;
      st_cnt <= 32'd0;
    end else begin
      if (bus.MEM_V && !busy && (misalign || fault)) err_q <= 1'b1;
      if (accept) begin
        if (is_store) st_cnt <= st_cnt + 32'd1;
        else          ld_cnt <= ld_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  clr_state_t state_dbg;

  always #5 clk = ~clk;

  dmem_responder_if bus ();

  dmem_responder #(.DEPTH_DW(256)) dut (
    .CLK       (clk),
    .RESET     (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];
  logic [7:0]  ref_mem [2048];
  logic [31:0] exp_ld = 0;
  logic [31:0] exp_st = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%h, expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic ref_clear();
    for (int i = 0; i < 2048; i++) ref_mem[i] = 8'h00;
    exp_ld = 0;
    exp_st = 0;
  endtask

  // Byte-level reference load: gather little-endian bytes, then extend.
  function automatic logic [63:0] ref_load(input logic [2:0] sz, input int a);
    logic [63:0] v;
    int nb;
    v  = 64'd0;
    nb = 1 << sz[1:0];
    for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[a + i];
    case (sz)
      SZ_B:    if (v[7])  v[63:8]  = '1;
      SZ_H:    if (v[15]) v[63:16] = '1;
      SZ_W:    if (v[31]) v[63:32] = '1;
      default: ;
    endcase
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    bus.MEM_V  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    ref_clear();
  endtask

  // Drive at the falling edge, leave 2 time units to settle before sampling.
  task automatic drive(input logic rw, input logic [2:0] sz, input logic [63:0] a,
                       input logic [63:0] d);
    @(negedge clk);
    bus.MEM_V        = 1'b1;
    bus.MEM_Cst_R_W  = rw;
    bus.MEM_Cst_Size = sz;
    bus.MEM_Address  = a;
    bus.MEM_RES      = d;
    #2;
  endtask

  task automatic idle(input logic [63:0] a);
    @(negedge clk);
    bus.MEM_V        = 1'b0;
    bus.MEM_Cst_R_W  = RW_LOAD;
    bus.MEM_Cst_Size = SZ_D;
    bus.MEM_Address  = a;
    bus.MEM_RES      = 64'hFFFF_FFFF_FFFF_FFFF;
    #2;
  endtask

  task automatic load_chk(input string tag, input logic [2:0] sz, input logic [63:0] a,
                          input logic [63:0] exp);
    exp_q.push_back(exp);
    drive(RW_LOAD, sz, a, 64'd0);
    chk(tag, bus.MEM_Data_Out, exp_q.pop_front());
    chk({tag, "_mis"}, 64'(bus.DMEM_MISALIGN), 64'd0);
    chk({tag, "_flt"}, 64'(bus.DMEM_FAULT), 64'd0);
    exp_ld++;
  endtask

  task automatic store_ok(input string tag, input logic [2:0] sz, input int a,
                          input logic [63:0] d);
    int nb;
    drive(RW_STORE, sz, 64'(a), d);
    chk({tag, "_mis"}, 64'(bus.DMEM_MISALIGN), 64'd0);
    chk({tag, "_flt"}, 64'(bus.DMEM_FAULT), 64'd0);
    nb = 1 << sz[1:0];
    for (int i = 0; i < nb; i++) ref_mem[a + i] = d[8*i +: 8];
    exp_st++;
  endtask

  // Counts sampled cycles with BUSY high, starting at the current sample
  // point. Optionally issues a store part-way through the clear.
  task automatic count_busy(input bit inject, output int cnt);
    cnt = 0;
    while (bus.DMEM_BUSY === 1'b1 && cnt < 1000) begin
      cnt++;
      @(negedge clk);
      if (inject && cnt == 50) begin
        bus.MEM_V        = 1'b1;
        bus.MEM_Cst_R_W  = RW_STORE;
        bus.MEM_Cst_Size = SZ_D;
        bus.MEM_Address  = 64'h40;
        bus.MEM_RES      = 64'h0123_4567_89AB_CDEF;
      end else begin
        bus.MEM_V = 1'b0;
      end
      #2;
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int          cnt;
    int          a, la;
    logic [2:0]  sz, lsz;
    logic [63:0] d;

    rst              = 1'b1;
    bus.MEM_V        = 1'b0;
    bus.MEM_Cst_R_W  = RW_LOAD;
    bus.MEM_Cst_Size = SZ_D;
    bus.MEM_Address  = 64'd0;
    bus.MEM_RES      = 64'd0;

    // Reset state and clear length.
    do_reset();
    #2;
    chk("rst_busy",  64'(bus.DMEM_BUSY), 64'd1);
    chk("rst_err",   64'(bus.DMEM_ERR), 64'd0);
    chk("rst_ldcnt", 64'(bus.DMEM_LD_CNT), 64'd0);
    chk("rst_stcnt", 64'(bus.DMEM_ST_CNT), 64'd0);
    chk("rst_dout",  bus.MEM_Data_Out, 64'd0);
    chk("rst_state", 64'(state_dbg), 64'(ST_CLEAR));
    count_busy(1'b0, cnt);
    chk("busy_len", 64'(cnt), 64'd256);
    chk("ready_state", 64'(state_dbg), 64'(ST_READY));
    load_chk("ld_d_0", SZ_D, 64'h0, 64'h0);

    // Lane extraction and extension.
    store_ok("st_d_10", SZ_D, 'h10, 64'h8877_6655_4433_2211);
    load_chk("ld_b_17",  SZ_B,  64'h17, 64'hFFFF_FFFF_FFFF_FF88);
    load_chk("ld_bu_17", SZ_BU, 64'h17, 64'h0000_0000_0000_0088);
    load_chk("ld_hu_12", SZ_HU, 64'h12, 64'h0000_0000_0000_4433);
    load_chk("ld_h_16",  SZ_H,  64'h16, 64'hFFFF_FFFF_FFFF_8877);
    load_chk("ld_w_14",  SZ_W,  64'h14, 64'hFFFF_FFFF_8877_6655);
    load_chk("ld_wu_10", SZ_WU, 64'h10, 64'h0000_0000_4433_2211);

    // Byte store merges into existing doubleword; upper store bits ignored.
    store_ok("st_b_11", SZ_B, 'h11, 64'h1234_5678_9ABC_DEAB);
    load_chk("ld_d_10", SZ_D, 64'h10, 64'h8877_6655_4433_AB11);
    idle(64'h10);
    chk("st_cnt_2", 64'(bus.DMEM_ST_CNT), 64'(exp_st));

    // Store codes 1xx behave as their signed counterparts.
    store_ok("st_hu_30", SZ_HU, 'h32, 64'hFFFF_FFFF_FFFF_BEEF);
    load_chk("ld_d_30", SZ_D, 64'h30, 64'h0000_0000_BEEF_0000);

    // Top of the array.
    store_ok("st_d_7f8", SZ_D, 'h7F8, 64'hA5A5_0F0F_C3C3_7E7E);
    load_chk("ld_d_7f8", SZ_D, 64'h7F8, 64'hA5A5_0F0F_C3C3_7E7E);
    load_chk("ld_b_7ff", SZ_B, 64'h7FF, 64'hFFFF_FFFF_FFFF_FFA5);

    // Random aligned store / load pairs against the byte model.
    for (int k = 0; k < 16; k++) begin
      sz  = 3'($urandom_range(0, 3));
      a   = $urandom_range(0, 2047) & ~((1 << sz[1:0]) - 1);
      d   = {$urandom, $urandom};
      store_ok("st_rnd", sz, a, d);
      lsz = 3'($urandom_range(0, 6));
      la  = a & ~((1 << lsz[1:0]) - 1);
      load_chk("ld_rnd", lsz, 64'(la), ref_load(lsz, la));
    end

    // Error handling: misaligned store, out-of-range and illegal loads.
    idle(64'h0);
    chk("pre_err", 64'(bus.DMEM_ERR), 64'd0);
    drive(RW_STORE, SZ_W, 64'h6, 64'h0000_0000_CAFE_BABE);
    chk("mis_st_w6",  64'(bus.DMEM_MISALIGN), 64'd1);
    chk("mis_st_flt", 64'(bus.DMEM_FAULT), 64'd0);
    idle(64'h6);
    chk("err_set", 64'(bus.DMEM_ERR), 64'd1);
    chk("idle_mis", 64'(bus.DMEM_MISALIGN), 64'd0);
    chk("idle_dout", bus.MEM_Data_Out, 64'd0);
    load_chk("ld_d_0_after", SZ_D, 64'h0, ref_load(SZ_D, 0));
    drive(RW_LOAD, SZ_D, 64'h800, 64'd0);
    chk("flt_800", 64'(bus.DMEM_FAULT), 64'd1);
    chk("flt_800_dout", bus.MEM_Data_Out, 64'd0);
    drive(RW_LOAD, SZ_ILL, 64'h10, 64'd0);
    chk("flt_ill", 64'(bus.DMEM_FAULT), 64'd1);
    chk("flt_ill_dout", bus.MEM_Data_Out, 64'd0);
    drive(RW_STORE, SZ_D, 64'h1_0000_0000, 64'h1);
    chk("flt_hi_st", 64'(bus.DMEM_FAULT), 64'd1);
    drive(RW_LOAD, SZ_H, 64'h13, 64'd0);
    chk("mis_ld_h", 64'(bus.DMEM_MISALIGN), 64'd1);
    chk("mis_ld_dout", bus.MEM_Data_Out, 64'd0);
    idle(64'h800);
    chk("idle_flt", 64'(bus.DMEM_FAULT), 64'd0);
    chk("err_ldcnt", 64'(bus.DMEM_LD_CNT), 64'(exp_ld));
    chk("err_stcnt", 64'(bus.DMEM_ST_CNT), 64'(exp_st));
    chk("err_sticky", 64'(bus.DMEM_ERR), 64'd1);

    // Activity during the clear, then reset mid-clear.
    do_reset();
    #2;
    chk("rst2_err", 64'(bus.DMEM_ERR), 64'd0);
    drive(RW_STORE, SZ_D, 64'h20, 64'hDEAD_BEEF_DEAD_BEEF);
    chk("busy_st_busy", 64'(bus.DMEM_BUSY), 64'd1);
    drive(RW_STORE, SZ_W, 64'h6, 64'h1);
    chk("busy_mis", 64'(bus.DMEM_MISALIGN), 64'd1);
    exp_q.push_back(64'd0);
    drive(RW_LOAD, SZ_D, 64'h0, 64'd0);
    chk("busy_ld", bus.MEM_Data_Out, exp_q.pop_front());
    idle(64'h0);
    chk("busy_err", 64'(bus.DMEM_ERR), 64'd0);
    chk("busy_stcnt", 64'(bus.DMEM_ST_CNT), 64'd0);
    chk("busy_ldcnt", 64'(bus.DMEM_LD_CNT), 64'd0);
    repeat (95) @(negedge clk);
    chk("mid_clear_busy", 64'(bus.DMEM_BUSY), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ref_clear();
    #2;
    count_busy(1'b1, cnt);
    chk("busy_len_restart", 64'(cnt), 64'd256);
    load_chk("ld_d_20_cleared", SZ_D, 64'h20, 64'd0);
    load_chk("ld_d_40_ignored", SZ_D, 64'h40, 64'd0);
    idle(64'h0);
    chk("end_stcnt", 64'(bus.DMEM_ST_CNT), 64'd0);
    chk("end_ldcnt", 64'(bus.DMEM_LD_CNT), 64'(exp_ld));
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
